// File: rtl/sim_supervisor_pkg.sv
// Shared types for the simulation supervisor: FSM state and verdict cause
// encodings, plus a helper telling whether a verdict has been reached.
package sim_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_REPORT = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CS_PASS     = 2'd0,
        CS_ERROR    = 2'd1,
        CS_WATCHDOG = 2'd2,
        CS_MAXCYC   = 2'd3
    } cause_e;

    localparam cause_e CAUSE_PASS = CS_PASS;

    // True once the verdict is fixed (presented or already accepted).
    function automatic logic verdict_reached(input state_e s);
        return (s == ST_REPORT) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Holds at all ones instead of wrapping.
module sim_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, else increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sim_supervisor.sv
// End-of-simulation supervisor: watches completion, error and activity
// reports and turns them into a pass/fail verdict offered on END_VALID/END_ACK.
// Optional: define SIM_SUPERVISOR_FINISH_EN to print the verdict and call
// $finish when the verdict is accepted (simulation only).
module sim_supervisor
    import sim_supervisor_pkg::*;
#(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned WDG_CYCLES   = 200,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic             USER_CLK,
    input  logic             USER_RST,
    input  logic             ACTIVITY,
    input  logic [N_SRC-1:0] DONE_REQ,
    input  logic             ERROR_REQ,
    input  logic             END_ACK,
    output logic             END_VALID,
    output logic             END_PASS,
    output logic [1:0]       END_CAUSE,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] CYCLE_COUNT
);

    localparam logic [CNT_W:0] MAX_LIM   = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [CNT_W:0] WDG_LIM   = (CNT_W + 1)'(WDG_CYCLES);
    localparam logic [CNT_W:0] DRAIN_LIM = (CNT_W + 1)'(DRAIN_CYCLES);
    localparam logic [CNT_W:0] ONE       = (CNT_W + 1)'(1);

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic [N_SRC-1:0]   done_mask_q, done_mask_d;

    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   wdg_count;
    logic [CNT_W-1:0]   drain_count;
    logic [CNT_W:0]     cycle_inc;
    logic [CNT_W:0]     wdg_inc;
    logic [CNT_W:0]     drain_inc;
    logic               cycle_limit;
    logic               wdg_expire;
    logic               drain_done;
    logic               in_run;
    logic               in_drain;

    assign in_run   = (state_q == ST_RUN);
    assign in_drain = (state_q == ST_DRAIN);

    // Supervised cycles: only RUN and DRAIN advance it; frozen once a verdict exists.
    sim_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk    (USER_CLK),
        .rst    (USER_RST),
        .clear  (1'b0),
        .enable (in_run || in_drain),
        .count  (cycle_count)
    );

    // Consecutive idle cycles; any activity restarts the count.
    sim_sat_counter #(.WIDTH(CNT_W)) u_wdg_cnt (
        .clk    (USER_CLK),
        .rst    (USER_RST),
        .clear  (ACTIVITY),
        .enable (in_run),
        .count  (wdg_count)
    );

    // Edges spent draining; held at zero outside DRAIN so each drain starts fresh.
    sim_sat_counter #(.WIDTH(CNT_W)) u_drain_cnt (
        .clk    (USER_CLK),
        .rst    (USER_RST),
        .clear  (!in_drain),
        .enable (in_drain),
        .count  (drain_count)
    );

    // Limits are judged on the value each counter takes at this edge.
    assign cycle_inc   = {1'b0, cycle_count} + ONE;
    assign wdg_inc     = {1'b0, wdg_count} + ONE;
    assign drain_inc   = {1'b0, drain_count} + ONE;
    assign cycle_limit = (cycle_inc >= MAX_LIM);
    assign wdg_expire  = !ACTIVITY && (wdg_inc >= WDG_LIM);
    assign drain_done  = (drain_inc >= DRAIN_LIM);

    // Next state, verdict cause and sticky done mask.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        done_mask_d = done_mask_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                done_mask_d = done_mask_q | DONE_REQ;
                if (ERROR_REQ) begin
                    state_d = ST_REPORT;
                    cause_d = CS_ERROR;
                end else if (wdg_expire) begin
                    state_d = ST_REPORT;
                    cause_d = CS_WATCHDOG;
                end else if (cycle_limit) begin
                    state_d = ST_REPORT;
                    cause_d = CS_MAXCYC;
                end else if (&done_mask_d) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ERROR_REQ) begin
                    state_d = ST_REPORT;
                    cause_d = CS_ERROR;
                end else if (cycle_limit) begin
                    state_d = ST_REPORT;
                    cause_d = CS_MAXCYC;
                end else if (drain_done) begin
                    state_d = ST_REPORT;
                    cause_d = CAUSE_PASS;
                end
            end
            ST_REPORT: begin
                if (END_ACK) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, cause and done mask registers; reset returns to IDLE from anywhere.
    always_ff @(posedge USER_CLK or posedge USER_RST) begin
        if (USER_RST) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_PASS;
            done_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            done_mask_q <= done_mask_d;
        end
    end

    assign END_VALID   = (state_q == ST_REPORT);
    assign END_PASS    = verdict_reached(state_q) && (cause_q == CAUSE_PASS);
    assign END_CAUSE   = cause_q;
    assign STATE       = state_q;
    assign CYCLE_COUNT = cycle_count;

`ifdef SIM_SUPERVISOR_FINISH_EN
    // Announce the accepted verdict and end the simulation on that edge.
    always @(posedge USER_CLK) begin
        if (!USER_RST && (state_q == ST_REPORT) && END_ACK) begin
            $display("sim_supervisor: verdict cause=%0d cycles=%0d", cause_q, cycle_count);
            $finish;
        end
    end
`else
`endif

endmodule
